// File: rtl/uart_tx_fsm_if.sv
// Signal bundle between the UART TX frame controller, its upstream byte
// source and the serializer. Clock and reset stay outside as plain ports.
interface uart_tx_fsm_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_data;
    logic                  ser_done;
    logic                  ser_en;
    logic                  busy;
    logic                  TX_OUT;

    // Environment side: byte source plus serializer feedback.
    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, busy, TX_OUT
    );

    // Frame controller side.
    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, busy, TX_OUT
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: start bit, LSB-first data bits taken from
// the serializer, optional parity bit, stop bit. Parity and the parity enable
// are captured when a byte is accepted so later input changes cannot corrupt
// the frame in flight. Outputs are Moore-decoded except TX_OUT in DATA.
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  par_bit;
    logic                  par_en_q;
    logic                  accept;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  tx_out;
    logic                  busy;
    logic                  ser_en;

    assign p_data = bus.P_DATA;
    assign accept = (state == IDLE) && bus.Data_Valid;

    // State register; reset drops the line back to idle mid-frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture parity configuration and the parity bit on byte acceptance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else if (accept) begin
            par_en_q <= bus.PAR_EN;
            par_bit  <= bus.PAR_TYP ? ~^p_data : ^p_data;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next = state;
        tx_out     = 1'b1;
        busy       = 1'b0;
        ser_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    state_next = START;
                end
            end
            START: begin
                tx_out     = 1'b0;
                busy       = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                tx_out = bus.ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
                if (bus.ser_done) begin
                    state_next = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_out     = par_bit;
                busy       = 1'b1;
                state_next = STOP;
            end
            STOP: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.TX_OUT = tx_out;
    assign bus.busy   = busy;
    assign bus.ser_en = ser_en;

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame controller for the UART transmitter: accepts a byte on `Data_Valid`, sequences start bit, data bits, optional parity bit and stop bit onto `TX_OUT`, and drives the serializer's `ser_en` and `busy` inputs. It sits directly downstream of the serializer: it consumes `ser_data`/`ser_done` and is the only driver of the UART TX line. Parity is computed internally from `P_DATA` at frame acceptance.

## Interface
- `DATA_WIDTH`, default 8 (from `parameters_pkg`): payload bits per frame.
- `CLK`  in  1  TX clock; one bit per cycle on `TX_OUT`.
- `RST`  in  1  asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH  parallel byte; sampled for parity on acceptance.
- `Data_Valid`  in  1  request to transmit `P_DATA`.
- `PAR_EN`  in  1  1 = insert parity bit.
- `PAR_TYP`  in  1  0 = even, 1 = odd parity.
- `ser_data`  in  1  current data bit from the serializer (LSB first).
- `ser_done`  in  1  high while the serializer presents its last data bit.
- `ser_en`  out  1  shift enable to the serializer.
- `busy`  out  1  frame in progress; blocks new `Data_Valid` acceptance.
- `TX_OUT`  out  1  serial line, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. State register and parity/config registers reset asynchronously; everything else is decoded from state (Moore), except `TX_OUT` in DATA, which passes `ser_data`.
- Reset values: state = IDLE, `TX_OUT` = 1, `busy` = 0, `ser_en` = 0, latched parity = 0, latched PAR_EN = 0.
- IDLE: `TX_OUT`=1, `busy`=0, `ser_en`=0. If `Data_Valid`=1, go to START and on the same edge latch `PAR_EN`, plus parity bit = `^P_DATA` (even) or `~^P_DATA` (odd) per `PAR_TYP`. The serializer loads `P_DATA` on that same edge because `busy`=0.
- START: `TX_OUT`=0, `busy`=1, `ser_en`=0. Always goes to DATA.
- DATA: `TX_OUT`=`ser_data`, `busy`=1, `ser_en`=1.
  - Stays in DATA while `ser_done`=0.
  - When `ser_done`=1, the current bit is the last one: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: `TX_OUT` = latched parity bit, `busy`=1, `ser_en`=0. Always goes to STOP.
- STOP: `TX_OUT`=1, `busy`=1, `ser_en`=0. Always goes to IDLE.
- `Data_Valid` is ignored in every state except IDLE. A held `Data_Valid` starts a new frame on the first IDLE cycle.
- Changes to `PAR_EN`, `PAR_TYP` or `P_DATA` after acceptance have no effect on the current frame.
- `ser_done` outside DATA is ignored.
- Reset asserted mid-frame: immediate return to IDLE with `TX_OUT`=1. No partial stop bit or parity bit is sent.

## Timing
- Acceptance edge to start bit on `TX_OUT`: 1 cycle. The start bit occupies the first cycle after the acceptance edge.
- Each bit lasts exactly 1 CLK cycle.
- Frame length: 1 + DATA_WIDTH + 1 cycles without parity (10 at default), 1 + DATA_WIDTH + 2 cycles with parity (11).
- `busy` is high from START through STOP inclusive. It drops in the IDLE cycle after STOP.
- Minimum gap between frames is 1 IDLE cycle. Back-to-back throughput is 1 frame per 11 or 12 cycles.
- `ser_en` is high for exactly DATA_WIDTH consecutive cycles per frame. It deasserts the cycle after `ser_done`, which lets the serializer clear its count.
- Data bit order on `TX_OUT` is LSB first, as presented by `ser_data`.

## Test plan
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, 1-cycle `Data_Valid` -> `TX_OUT` = 0, 1,0,1,0,0,1,0,1, 0, 1, then idle 1. `busy` high for exactly 11 cycles.
- Same byte with `PAR_TYP`=1 -> parity bit = 1. With `PAR_EN`=0 -> parity slot removed, 10-cycle frame ending in stop bit 1.
- `P_DATA`=0xFF, even parity -> parity 0. `P_DATA`=0x01, odd parity -> parity 0. `ser_en` high exactly 8 cycles and low in the START/PARITY/STOP cycles.
- `Data_Valid` held high continuously, with `P_DATA` changed mid-frame from 0x3C to 0xC3 -> first frame carries 0x3C intact. A second frame (0xC3) starts after exactly 1 IDLE cycle.
- Toggling `PAR_EN` or `PAR_TYP` during DATA -> current frame uses the values latched at acceptance.
- `RST` pulsed low during DATA bit 4 -> `TX_OUT`=1, `busy`=0, `ser_en`=0 immediately (asynchronously). The next `Data_Valid` produces a complete, correct frame.
